wb_cache: RTL and testbench
===========================

// Module: wb_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU and the memory controller.
//  Serves word reads/writes from the CPU and stalls the CPU (proc_hold) on misses and flushes.
//  Exchanges whole lines with the memory controller through a request/ready handshake.
//  A flush command writes every dirty line back to memory.
// PARAMETERS
//  DATA_WIDTH   32  CPU word width (bits)
//  ADDR_WIDTH   12  CPU word-address width
//  INDEX_BITS    6  line index bits (64 lines)
//  OFFSET_BITS   2  word-in-line bits (4 words/line); TAG = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS
//  LINE_W = DATA_WIDTH<<OFFSET_BITS (derived)
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           asynchronous, active-high reset
//  proc_cs     in   1           CPU request valid
//  proc_rw     in   1           0=read, 1=write
//  proc_flush  in   1           with proc_cs: flush all dirty lines (overrides proc_rw)
//  proc_addr   in   ADDR_WIDTH  word address {tag,index,offset}
//  proc_wdata  in   DATA_WIDTH  write data
//  proc_hold   out  1           stall CPU; request completes in the cycle it is low
//  proc_rdata  out  DATA_WIDTH  read data, valid when proc_cs&~proc_rw&~proc_hold
//  mem_cs      out  1           memory request valid, held until mem_ready
//  mem_rw      out  1           0=line read, 1=line write
//  mem_addr    out  ADDR_WIDTH-OFFSET_BITS  line address {tag,index}
//  mem_wdata   out  LINE_W      line write data (word 0 in LSBs)
//  mem_rdata   in   LINE_W      line read data, valid with mem_ready
//  mem_ready   in   1           one-cycle pulse: current memory request done
// BEHAVIOUR
//  Storage: per line valid, dirty, tag, LINE_W data.
//  Reset (async): all valid/dirty=0, FSM=IDLE, mem_cs=0, mem_rw=0; proc_hold=0 while proc_cs=0.
//   Reset mid-operation aborts any memory request immediately; dirty data is discarded.
//  FSM states: IDLE, WRITEBACK, ALLOCATE, FLUSH.
//  IDLE: hit = valid[idx] & tag match.
//   cs=0: hold=0, nothing happens.
//   read hit: hold=0 combinationally; proc_rdata = selected word same cycle (0-cycle latency).
//   write hit: hold=0; word written and dirty=1 at the rising edge.
//   miss, victim dirty: hold=1, go WRITEBACK. Miss, victim clean/invalid: hold=1, go ALLOCATE.
//   cs&flush: hold=1, index counter=0, go FLUSH.
//  WRITEBACK: mem_cs=1, mem_rw=1, mem_addr={victim tag,idx}, mem_wdata=victim line; on mem_ready
//   clear dirty, go ALLOCATE.
//  ALLOCATE: mem_cs=1, mem_rw=0, mem_addr={req tag,idx}; on mem_ready write line, valid=1,
//   dirty=0, tag=req tag; go IDLE, where the request now hits (miss costs mem latency + 1 cycle).
//  FLUSH: scan index 0..2^INDEX_BITS-1; dirty line -> write-back request, wait mem_ready, clear
//   dirty; clean line skipped in one cycle. After last index go IDLE; hold=0 for one cycle while
//   cs&flush still high, then flush completes (lines stay valid). Re-issuing flush with no dirty
//   lines still scans all indices.
//  proc_hold is 1 in every non-IDLE state; inputs must stay stable while hold=1.
//  mem_cs/mem_rw/mem_addr/mem_wdata are registered and stable for the whole request;
//   mem_cs drops the cycle after mem_ready. mem_ready while mem_cs=0 is ignored.
//  Write miss: allocate then perform the write in IDLE (write-allocate).
// TESTING
//  After reset, read 0x010 with memory line 0x004 = {4,3,2,1} -> hold high, one ALLOCATE read of
//   line 0x004, then rdata=0x00000001 with hold low; re-read 0x011 -> rdata=2, hold never high.
//  Write 0x012 <- 0xDEADBEEF (hit) -> no memory traffic; read 0x012 returns 0xDEADBEEF.
//  Read 0x412 (same index, other tag) -> WRITEBACK of line 0x004 carrying 0xDEADBEEF in word 2,
//   then ALLOCATE of line 0x104, then data returned.
//  Write miss 0x820 <- 0x12345678 on clean index -> only ALLOCATE, then word written, dirty=1.
//  Flush with 2 dirty lines -> exactly 2 memory writes with correct lines, hold released at end,
//   second flush -> zero memory writes.
//  Assert rst while in ALLOCATE -> mem_cs=0 and hold=0 immediately; next read of same address misses.

Source files
------------

// File: rtl/wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : wb_cache
// Purpose  : Direct-mapped, write-back, write-allocate data cache placed
//            between the CPU and the memory controller. Hits are served with
//            zero latency. Misses and flushes stall the CPU through proc_hold
//            while whole lines move over a request/ready memory handshake.
// Ports    : clk, rst (async, active-high)
//            proc_cs/proc_rw/proc_flush/proc_addr/proc_wdata -> CPU request
//            proc_hold/proc_rdata                            <- CPU response
//            mem_cs/mem_rw/mem_addr/mem_wdata                -> line request
//            mem_rdata/mem_ready                             <- line response
// Revision : 1.0 - initial release
// ============================================================================
module wb_cache #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int LINE_W      = DATA_WIDTH << OFFSET_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          proc_cs,
    input  logic                          proc_rw,
    input  logic                          proc_flush,
    input  logic [ADDR_WIDTH-1:0]         proc_addr,
    input  logic [DATA_WIDTH-1:0]         proc_wdata,
    output logic                          proc_hold,
    output logic [DATA_WIDTH-1:0]         proc_rdata,
    output logic                          mem_cs,
    output logic                          mem_rw,
    output logic [ADDR_WIDTH-OFFSET_BITS-1:0] mem_addr,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic [LINE_W-1:0]             mem_rdata,
    input  logic                          mem_ready
);

    localparam int c_TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int c_LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_FLUSH     = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_LINES-1:0]        r_valid;
    logic [c_LINES-1:0]        r_dirty;
    logic [c_TAG_BITS-1:0]     r_tag  [c_LINES];
    logic [LINE_W-1:0]         r_data [c_LINES];
    logic [INDEX_BITS-1:0]     r_fidx;
    // Set when a flush scan finishes so the next IDLE cycle completes the
    // still-pending flush request instead of starting a new scan.
    logic                      r_flush_done;

    logic [c_TAG_BITS-1:0]     w_tag;
    logic [INDEX_BITS-1:0]     w_idx;
    logic [OFFSET_BITS-1:0]    w_off;
    logic                      w_hit;
    logic                      w_wr_hit;
    logic                      w_fill;
    logic                      w_flush_last;
    logic [LINE_W-1:0]         w_line;

    assign w_tag        = proc_addr[ADDR_WIDTH-1 -: c_TAG_BITS];
    assign w_idx        = proc_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_off        = proc_addr[OFFSET_BITS-1:0];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line       = r_data[w_idx];
    assign w_wr_hit     = (r_state == S_IDLE) && proc_cs && !proc_flush && proc_rw && w_hit;
    assign w_fill       = (r_state == S_ALLOCATE) && mem_cs && mem_ready;
    assign w_flush_last = (r_fidx == {INDEX_BITS{1'b1}});

    // Zero-latency read path: the addressed word of the indexed line.
    assign proc_rdata = w_line[w_off*DATA_WIDTH +: DATA_WIDTH];

    // Hold is combinational so hits complete in the cycle they are presented.
    // It is forced low during reset so an aborted miss releases the CPU at once.
    always_comb begin
        proc_hold = 1'b0;
        if (rst) begin
            proc_hold = 1'b0;
        end else if (r_state != S_IDLE) begin
            proc_hold = 1'b1;
        end else if (proc_cs) begin
            if (proc_flush) begin
                proc_hold = !r_flush_done;
            end else begin
                proc_hold = !w_hit;
            end
        end
    end

    // Tag and data storage: no reset, contents are qualified by r_valid.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx] <= mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][w_off*DATA_WIDTH +: DATA_WIDTH] <= proc_wdata;
        end
    end

    // Control FSM with line status bits and registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_fidx       <= '0;
            r_flush_done <= 1'b0;
            mem_cs       <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flush_done <= 1'b0;
                    if (proc_cs) begin
                        if (proc_flush) begin
                            if (!r_flush_done) begin
                                r_state <= S_FLUSH;
                                r_fidx  <= '0;
                            end
                        end else if (w_hit) begin
                            if (proc_rw) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state   <= S_WRITEBACK;
                            mem_cs    <= 1'b1;
                            mem_rw    <= 1'b1;
                            mem_addr  <= {r_tag[w_idx], w_idx};
                            mem_wdata <= r_data[w_idx];
                        end else begin
                            r_state  <= S_ALLOCATE;
                            mem_cs   <= 1'b1;
                            mem_rw   <= 1'b0;
                            mem_addr <= {w_tag, w_idx};
                        end
                    end
                end

                S_WRITEBACK: begin
                    if (mem_cs && mem_ready) begin
                        r_dirty[w_idx] <= 1'b0;
                        mem_cs         <= 1'b0;
                        r_state        <= S_ALLOCATE;
                    end
                end

                S_ALLOCATE: begin
                    // Entered with mem_cs low after a write-back: the line
                    // read is issued one cycle later so mem_cs visibly drops
                    // between the two requests.
                    if (!mem_cs) begin
                        mem_cs   <= 1'b1;
                        mem_rw   <= 1'b0;
                        mem_addr <= {w_tag, w_idx};
                    end else if (mem_ready) begin
                        mem_cs         <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end

                S_FLUSH: begin
                    if (!mem_cs) begin
                        if (r_dirty[r_fidx]) begin
                            mem_cs    <= 1'b1;
                            mem_rw    <= 1'b1;
                            mem_addr  <= {r_tag[r_fidx], r_fidx};
                            mem_wdata <= r_data[r_fidx];
                        end else if (w_flush_last) begin
                            r_state      <= S_IDLE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_fidx <= r_fidx + 1'b1;
                        end
                    end else if (mem_ready) begin
                        r_dirty[r_fidx] <= 1'b0;
                        mem_cs          <= 1'b0;
                        if (w_flush_last) begin
                            r_state      <= S_IDLE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_fidx <= r_fidx + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    mem_cs  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cache
// Purpose  : Directed self-checking bench for wb_cache with a line-memory
//            responder (fixed latency) that logs every line transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cache;

    logic         clk;
    logic         rst;
    logic         proc_cs;
    logic         proc_rw;
    logic         proc_flush;
    logic [11:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_hold;
    logic [31:0]  proc_rdata;
    logic         mem_cs;
    logic         mem_rw;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    wb_cache dut (
        .clk        (clk),
        .rst        (rst),
        .proc_cs    (proc_cs),
        .proc_rw    (proc_rw),
        .proc_flush (proc_flush),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_hold  (proc_hold),
        .proc_rdata (proc_rdata),
        .mem_cs     (mem_cs),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [127:0] mem [0:1023];
    logic         mem_init;
    int           lat_cnt;
    int           n_wr;
    int           n_rd;
    logic [9:0]   last_rd_addr;
    logic [9:0]   wr_addr_log [0:15];
    logic [127:0] wr_data_log [0:15];

    initial begin
        mem_init     = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        lat_cnt      = 0;
        n_wr         = 0;
        n_rd         = 0;
        last_rd_addr = '0;
    end

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = '0;
            mem[10'h004] = {32'h4,  32'h3,  32'h2,  32'h1};
            mem[10'h104] = {32'h14, 32'h13, 32'h12, 32'h11};
            mem[10'h208] = {32'h24, 32'h23, 32'h22, 32'h21};
            mem[10'h00C] = {32'h34, 32'h33, 32'h32, 32'h31};
            mem_init = 1'b1;
        end
        if (rst) begin
            mem_ready = 1'b0;
            lat_cnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_cs) begin
            lat_cnt++;
            if (lat_cnt == 3) begin
                lat_cnt = 0;
                if (mem_rw) begin
                    mem[mem_addr] = mem_wdata;
                    if (n_wr < 16) begin
                        wr_addr_log[n_wr] = mem_addr;
                        wr_data_log[n_wr] = mem_wdata;
                    end
                    n_wr++;
                end else begin
                    mem_rdata    = mem[mem_addr];
                    last_rd_addr = mem_addr;
                    n_rd++;
                end
                mem_ready = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU request held until proc_hold is low; returns read data and the
    // number of stalled cycles.
    task automatic access(input logic rw, input logic fl, input logic [11:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output int hc);
        @(negedge clk);
        proc_cs    = 1'b1;
        proc_rw    = rw;
        proc_flush = fl;
        proc_addr  = addr;
        proc_wdata = wd;
        hc = 0;
        #1;
        while (proc_hold !== 1'b0 && hc < 400) begin
            @(negedge clk);
            #1;
            hc++;
        end
        chk("timeout", {127'd0, (hc >= 400)}, 128'd0);
        rd = proc_rdata;
        @(posedge clk);
        #1;
        proc_cs    = 1'b0;
        proc_rw    = 1'b0;
        proc_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int          hc;
    int          wt;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        proc_cs    = 1'b0;
        proc_rw    = 1'b0;
        proc_flush = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_hold",   {127'd0, proc_hold}, 128'd0);
        chk("rst_mem_cs", {127'd0, mem_cs},    128'd0);
        chk("rst_mem_rw", {127'd0, mem_rw},    128'd0);

        // Cold read miss -> single allocate of line 0x004
        access(1'b0, 1'b0, 12'h010, 32'h0, rd, hc);
        chk("miss_stalls", {127'd0, (hc > 0)}, 128'd1);
        chk("miss_rdata",  {96'd0, rd}, {96'd0, 32'h1});
        chk("miss_nrd",    n_rd, 1);
        chk("miss_rdaddr", {118'd0, last_rd_addr}, {118'd0, 10'h004});
        chk("miss_nwr",    n_wr, 0);

        // Read hit, zero latency
        access(1'b0, 1'b0, 12'h011, 32'h0, rd, hc);
        chk("hit_rdata", {96'd0, rd}, {96'd0, 32'h2});
        chk("hit_hc",    hc, 0);

        // Write hit then read back, no memory traffic
        access(1'b1, 1'b0, 12'h012, 32'hDEADBEEF, rd, hc);
        chk("whit_hc", hc, 0);
        access(1'b0, 1'b0, 12'h012, 32'h0, rd, hc);
        chk("whit_rdata", {96'd0, rd}, {96'd0, 32'hDEADBEEF});
        chk("whit_hc2",   hc, 0);
        chk("whit_nwr",   n_wr, 0);
        chk("whit_nrd",   n_rd, 1);

        // Conflict miss with dirty victim: write-back then allocate
        access(1'b0, 1'b0, 12'h412, 32'h0, rd, hc);
        chk("wb_rdata",  {96'd0, rd}, {96'd0, 32'h13});
        chk("wb_nwr",    n_wr, 1);
        chk("wb_addr",   {118'd0, wr_addr_log[0]}, {118'd0, 10'h004});
        chk("wb_data",   wr_data_log[0], {32'h4, 32'hDEADBEEF, 32'h2, 32'h1});
        chk("wb_nrd",    n_rd, 2);
        chk("wb_rdaddr", {118'd0, last_rd_addr}, {118'd0, 10'h104});

        // Write miss on clean index: allocate only, then write
        access(1'b1, 1'b0, 12'h820, 32'h12345678, rd, hc);
        chk("wmiss_stalls", {127'd0, (hc > 0)}, 128'd1);
        chk("wmiss_nwr",    n_wr, 1);
        chk("wmiss_nrd",    n_rd, 3);
        chk("wmiss_rdaddr", {118'd0, last_rd_addr}, {118'd0, 10'h208});
        access(1'b0, 1'b0, 12'h820, 32'h0, rd, hc);
        chk("wmiss_rdata", {96'd0, rd}, {96'd0, 32'h12345678});
        chk("wmiss_hc",    hc, 0);

        // Second dirty line
        access(1'b1, 1'b0, 12'h413, 32'hCAFEF00D, rd, hc);
        chk("whit2_hc", hc, 0);

        // Flush: two dirty lines written in index order
        access(1'b0, 1'b1, 12'h000, 32'h0, rd, hc);
        chk("fl_nwr",   n_wr, 3);
        chk("fl_addr1", {118'd0, wr_addr_log[1]}, {118'd0, 10'h104});
        chk("fl_data1", wr_data_log[1], {32'hCAFEF00D, 32'h13, 32'h12, 32'h11});
        chk("fl_addr2", {118'd0, wr_addr_log[2]}, {118'd0, 10'h208});
        chk("fl_data2", wr_data_log[2], {32'h24, 32'h23, 32'h22, 32'h12345678});
        chk("fl_scan",  {127'd0, (hc >= 64)}, 128'd1);

        // Second flush: nothing dirty, full scan still happens
        access(1'b0, 1'b1, 12'h000, 32'h0, rd, hc);
        chk("fl2_nwr",  n_wr, 3);
        chk("fl2_scan", {127'd0, (hc >= 64)}, 128'd1);

        // Lines remain valid after flush
        access(1'b0, 1'b0, 12'h413, 32'h0, rd, hc);
        chk("postfl_rdata", {96'd0, rd}, {96'd0, 32'hCAFEF00D});
        chk("postfl_hc",    hc, 0);

        // Reset during ALLOCATE
        @(negedge clk);
        proc_cs   = 1'b1;
        proc_rw   = 1'b0;
        proc_addr = 12'h030;
        wt = 0;
        #1;
        while (mem_cs !== 1'b1 && wt < 20) begin
            @(negedge clk);
            #1;
            wt++;
        end
        chk("alloc_start", {127'd0, (wt < 20)}, 128'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_mem_cs", {127'd0, mem_cs},    128'd0);
        chk("rstmid_hold",   {127'd0, proc_hold}, 128'd0);
        @(negedge clk);
        proc_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 1'b0, 12'h030, 32'h0, rd, hc);
        chk("rerd_stalls", {127'd0, (hc > 0)}, 128'd1);
        chk("rerd_rdata",  {96'd0, rd}, {96'd0, 32'h31});
        access(1'b0, 1'b0, 12'h011, 32'h0, rd, hc);
        chk("inval_stalls", {127'd0, (hc > 0)}, 128'd1);
        chk("inval_rdata",  {96'd0, rd}, {96'd0, 32'h2});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
